// File: rtl/chacha_pkg.sv
// Shared types for the chacha stream sequencer: FSM state encoding and default byte counts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chacha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_KEY,
        LD_NNC,
        LD_CTR,
        WAIT_BLK,
        STREAM
    } seq_state_t;

    localparam int KEY_BYTES_DEF   = 32;
    localparam int NONCE_BYTES_DEF = 8;
    localparam int CTR_BYTES_DEF   = 8;
    localparam int BLK_BYTES_DEF   = 64;

    // Index register width able to count 0 .. max_count-1.
    function automatic int idx_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/chacha_xor_stage.sv
// One-entry ciphertext register: ct = pt ^ keystream, with pt/ct valid-ready.
// Latency: 1 cycle from accepted pt byte to ct_valid.
// Backpressure: in_ready = !ct_valid | ct_ready, so full throughput while ct_ready stays high.
module chacha_xor_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       load,
    input  logic [7:0] pt_data,
    input  logic [7:0] ks_data,
    output logic       in_ready,
    output logic [7:0] ct_data,
    output logic       ct_valid,
    input  logic       ct_ready
);

    assign in_ready = ~ct_valid | ct_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_data  <= 8'h00;
            ct_valid <= 1'b0;
        end else if (flush) begin
            ct_valid <= 1'b0;
        end else if (load) begin
            ct_data  <= pt_data ^ ks_data;
            ct_valid <= 1'b1;
        end else if (ct_ready) begin
            ct_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/chacha_stream_seq.sv
// Sequencer: loads key/nonce, writes block counter, then XORs 64 keystream bytes per block onto plaintext.
// Latency: pt->ct 1 cycle at 1 byte/cycle; optional CHACHA_STREAM_SEQ_SEEK_EN adds ctr_init seek input.
// Backpressure: cfg_valid low stalls loading; ct_ready low stalls pt_ready and core keystream reads.
module chacha_stream_seq
    import chacha_pkg::*;
#(
    parameter int KEY_BYTES   = KEY_BYTES_DEF,
    parameter int NONCE_BYTES = NONCE_BYTES_DEF,
    parameter int CTR_BYTES   = CTR_BYTES_DEF,
    parameter int BLK_BYTES   = BLK_BYTES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_load,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] pt_data,
    input  logic       pt_valid,
    output logic       pt_ready,
    output logic [7:0] ct_data,
    output logic       ct_valid,
    input  logic       ct_ready,
    output logic       busy,
    output logic       ctr_wrap,
    output logic       core_wr_key,
    output logic       core_wr_nnc,
    output logic       core_wr_ctr,
    output logic       core_rd_blk,
    output logic [7:0] core_din,
    input  logic [7:0] core_dout,
    input  logic       core_ready
`ifdef CHACHA_STREAM_SEQ_SEEK_EN
    ,
    input  logic [8*CTR_BYTES-1:0] ctr_init
`endif
);

    localparam int CW      = 8 * CTR_BYTES;
    localparam int MAX_A   = (KEY_BYTES > NONCE_BYTES) ? KEY_BYTES : NONCE_BYTES;
    localparam int MAX_B   = (CTR_BYTES > BLK_BYTES) ? CTR_BYTES : BLK_BYTES;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IW      = idx_width(MAX_CNT);

    localparam logic [IW-1:0] KEY_LAST = IW'(KEY_BYTES - 1);
    localparam logic [IW-1:0] NNC_LAST = IW'(NONCE_BYTES - 1);
    localparam logic [IW-1:0] CTR_LAST = IW'(CTR_BYTES - 1);
    localparam logic [IW-1:0] BLK_LAST = IW'(BLK_BYTES - 1);

    seq_state_t    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] ctr;
    logic [CW-1:0] ctr_start;
    logic [7:0]    ctr_byte;
    logic          stage_rdy;
    logic          cfg_fire;
    logic          pt_fire;

`ifdef CHACHA_STREAM_SEQ_SEEK_EN
    assign ctr_start = ctr_init;
`else
    assign ctr_start = '0;
`endif

    // A cmd_load in the same cycle aborts, so any concurrent cfg/pt transfer is dropped.
    assign cfg_fire    = cfg_valid & cfg_ready & ~cmd_load;
    assign pt_ready    = (state == STREAM) & stage_rdy;
    assign pt_fire     = pt_valid & pt_ready & ~cmd_load;

    assign core_wr_key = cfg_fire & (state == LD_KEY);
    assign core_wr_nnc = cfg_fire & (state == LD_NNC);
    assign core_wr_ctr = (state == LD_CTR) & ~cmd_load;
    assign core_rd_blk = pt_fire;

    always_comb begin
        ctr_byte = 8'h00;
        for (int i = 0; i < CTR_BYTES; i++) begin
            if (idx == IW'(i)) ctr_byte = ctr[i*8 +: 8];
        end
    end

    always_comb begin
        core_din = 8'h00;
        if (cfg_fire)         core_din = cfg_data;
        else if (core_wr_ctr) core_din = ctr_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            ctr       <= '0;
            ctr_wrap  <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
        end else if (cmd_load) begin
            state     <= LD_KEY;
            idx       <= '0;
            ctr       <= ctr_start;
            ctr_wrap  <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b1;
        end else begin
            case (state)
                LD_KEY: if (cfg_valid) begin
                    if (idx == KEY_LAST) begin
                        idx   <= '0;
                        state <= LD_NNC;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                LD_NNC: if (cfg_valid) begin
                    if (idx == NNC_LAST) begin
                        idx       <= '0;
                        state     <= LD_CTR;
                        cfg_ready <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                LD_CTR: begin
                    if (idx == CTR_LAST) begin
                        idx   <= '0;
                        state <= WAIT_BLK;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WAIT_BLK: if (core_ready) state <= STREAM;
                STREAM: if (pt_fire) begin
                    if (idx == BLK_LAST) begin
                        idx   <= '0;
                        ctr   <= ctr + 1'b1;
                        state <= LD_CTR;
                        if (&ctr) ctr_wrap <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    chacha_xor_stage u_xor (
        .clk      (clk),
        .rst      (rst),
        .flush    (cmd_load),
        .load     (pt_fire),
        .pt_data  (pt_data),
        .ks_data  (core_dout),
        .in_ready (stage_rdy),
        .ct_data  (ct_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready)
    );

    strobe_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0({core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk}));

endmodule

// File: tb/tb_chacha_stream_seq.sv
// Bench for chacha_stream_seq with a behavioural ChaCha20 (64-bit counter, 64-bit nonce) core model.
// Define CHACHA_STREAM_SEQ_SEEK_EN to exercise the ctr_init seek / counter wrap path.
module tb_chacha_stream_seq;

    logic       clk = 1'b0;
    logic       rst, cmd_load, cfg_valid, cfg_ready, pt_valid, pt_ready;
    logic       ct_valid, ct_ready, busy, ctr_wrap;
    logic       core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk, core_ready;
    logic [7:0] cfg_data, pt_data, ct_data, core_din, core_dout;
    logic [63:0] ctr_init;

    always #5 clk = ~clk;

    chacha_stream_seq dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .ctr_wrap(ctr_wrap),
        .core_wr_key(core_wr_key), .core_wr_nnc(core_wr_nnc),
        .core_wr_ctr(core_wr_ctr), .core_rd_blk(core_rd_blk),
        .core_din(core_din), .core_dout(core_dout), .core_ready(core_ready)
`ifdef CHACHA_STREAM_SEQ_SEEK_EN
        , .ctr_init(ctr_init)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ChaCha20 reference ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] ai, bi, ci, di);
        logic [31:0] a, b, c, d;
        a = ai; b = bi; c = ci; d = di;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] make_state(input logic [255:0] k, input logic [63:0] n,
                                                input logic [63:0] c);
        return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] s);
        logic [31:0] x[16];
        logic [511:0] r;
        for (int w = 0; w < 16; w++) x[w] = s[w*32 +: 32];
        for (int i = 0; i < 10; i++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int w = 0; w < 16; w++) r[w*32 +: 32] = x[w] + s[w*32 +: 32];
        return r;
    endfunction

    // ---------------- core model ----------------
    logic [255:0] mkey;
    logic [63:0]  mnnc, mctr;
    int           mk = 0, mn = 0, mc = 0, cd = 0, rd_i = 0;
    logic [7:0]   blk[64];
    logic [511:0] mks;

    assign core_dout = blk[rd_i];

    initial core_ready = 1'b0;
    always @(posedge clk) begin
        if (core_wr_key) begin mkey[mk*8 +: 8] = core_din; mk = (mk + 1) % 32; end
        if (core_wr_nnc) begin mnnc[mn*8 +: 8] = core_din; mn = (mn + 1) % 8; end
        if (core_wr_ctr) begin
            mctr[mc*8 +: 8] = core_din;
            mc = (mc + 1) % 8;
            core_ready <= 1'b0;
            if (mc == 0) cd = 3;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mks = chacha_block(make_state(mkey, mnnc, mctr));
                for (int i = 0; i < 64; i++) blk[i] = mks[i*8 +: 8];
                rd_i       <= 0;
                core_ready <= 1'b1;
            end
        end
        if (core_rd_blk) rd_i <= (rd_i + 1) % 64;
    end

    // ---------------- monitors / sink ----------------
    logic [7:0] ct_q[$];
    logic [7:0] ctr_log[$];
    int         nkey = 0, nnnc = 0, key_at_nnc = 0;
    int         ct_mode = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ct_valid && ct_ready) ct_q.push_back(ct_data);
            if (core_wr_ctr) ctr_log.push_back(core_din);
            if (core_wr_nnc && nnnc == 0) key_at_nnc = nkey;
            if (core_wr_key) nkey++;
            if (core_wr_nnc) nnnc++;
        end
    end

    initial begin
        ct_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            case (ct_mode)
                0:       ct_ready = 1'b1;
                1:       ct_ready = 1'($urandom_range(0, 1));
                default: ct_ready = 1'b0;
            endcase
        end
    end

    // ---------------- drivers ----------------
    logic [7:0] cfg_buf[40];
    logic [7:0] pt_buf[128];

    task automatic send_cfg(input bit gaps);
        int i = 0, g = 0;
        bit fire;
        while (i < 40 && g < 2000) begin
            if (gaps && $urandom_range(0, 2) == 0) cfg_valid = 1'b0;
            else begin cfg_valid = 1'b1; cfg_data = cfg_buf[i]; end
            @(negedge clk); fire = cfg_valid && cfg_ready;
            @(posedge clk); #1;
            if (fire) i++;
            g++;
        end
        cfg_valid = 1'b0;
        if (i < 40) begin total++; bad++; $display("FAIL cfg_timeout: sent %0d need 40", i); end
    endtask

    task automatic send_pt(input int n, input bit gaps);
        int i = 0, g = 0;
        bit fire;
        while (i < n && g < 5000) begin
            if (gaps && $urandom_range(0, 2) == 0) pt_valid = 1'b0;
            else begin pt_valid = 1'b1; pt_data = pt_buf[i]; end
            @(negedge clk); fire = pt_valid && pt_ready;
            @(posedge clk); #1;
            if (fire) i++;
            g++;
        end
        pt_valid = 1'b0;
        if (i < n) begin total++; bad++; $display("FAIL pt_timeout: sent %0d need %0d", i, n); end
    endtask

    task automatic do_load(input logic [255:0] k, input logic [63:0] n, input bit gaps);
        for (int i = 0; i < 32; i++) cfg_buf[i] = k[i*8 +: 8];
        for (int i = 0; i < 8; i++) cfg_buf[32+i] = n[i*8 +: 8];
        @(posedge clk); #1;
        cmd_load = 1'b1; mk = 0; mn = 0; mc = 0; nkey = 0; nnnc = 0;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        send_cfg(gaps);
    endtask

    task automatic wait_q(input int n);
        int g = 0;
        while (ct_q.size() < n && g < 3000) begin @(negedge clk); g++; end
        if (ct_q.size() < n) begin
            total++; bad++;
            $display("FAIL ct_timeout: got %0d bytes need %0d", ct_q.size(), n);
        end
    endtask

    task automatic wait_ctr(input int n);
        int g = 0;
        while (ctr_log.size() < n && g < 3000) begin @(negedge clk); g++; end
        if (ctr_log.size() < n) begin
            total++; bad++;
            $display("FAIL ctr_timeout: got %0d writes need %0d", ctr_log.size(), n);
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ctl"}, {busy, cfg_ready, pt_ready, ct_valid, ctr_wrap,
                             core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk}, 0);
        chk({name, "_ct"}, ct_data, 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int         pos;
        logic [7:0] pt;
        logic [7:0] exp_ct;
    } vec_t;
    vec_t vt[16];

    logic [511:0] ref0, ref1, refk, reff;
    logic [255:0] key_k;
    logic [63:0]  nnc_k;

    initial begin
        rst = 1'b1; cmd_load = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        pt_valid = 1'b0; pt_data = 8'h00; ctr_init = '0;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;

        // ChaCha20 zero key/nonce keystream, blocks 0 and 1, first 8 bytes each.
        vt[0]  = '{0,  8'h00, 8'h76}; vt[1]  = '{1,  8'hff, 8'h47};
        vt[2]  = '{2,  8'h00, 8'he0}; vt[3]  = '{3,  8'h0f, 8'ha2};
        vt[4]  = '{4,  8'h00, 8'ha0}; vt[5]  = '{5,  8'hf1, 8'h00};
        vt[6]  = '{6,  8'h00, 8'h3d}; vt[7]  = '{7,  8'h01, 8'h91};
        vt[8]  = '{64, 8'h00, 8'h9f}; vt[9]  = '{65, 8'h07, 8'h00};
        vt[10] = '{66, 8'h00, 8'he7}; vt[11] = '{67, 8'hff, 8'h41};
        vt[12] = '{68, 8'h00, 8'h55}; vt[13] = '{69, 8'haa, 8'hfb};
        vt[14] = '{70, 8'h00, 8'h38}; vt[15] = '{71, 8'h80, 8'hfa};

        for (int i = 0; i < 32; i++) key_k[i*8 +: 8] = 8'(i + 1);
        for (int i = 0; i < 8; i++)  nnc_k[i*8 +: 8] = 8'(8'ha0 + i);
        ref0 = chacha_block(make_state('0, '0, 64'd0));
        ref1 = chacha_block(make_state('0, '0, 64'd1));
        refk = chacha_block(make_state(key_k, nnc_k, 64'd0));
        reff = chacha_block(make_state('0, '0, '1));

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Tests 1/2: two consecutive blocks, zero key/nonce, counter 0 then 1.
        for (int i = 0; i < 128; i++) pt_buf[i] = 8'h00;
        for (int i = 0; i < 16; i++) pt_buf[vt[i].pos] = vt[i].pt;
        ctr_log.delete(); ct_q.delete();
        do_load('0, '0, 1'b0);
        send_pt(128, 1'b0);
        wait_q(128);
        for (int i = 0; i < 16; i++)
            chk($sformatf("vec%0d_pos%0d", i, vt[i].pos), ct_q[vt[i].pos], vt[i].exp_ct);
        for (int i = 0; i < 128; i++)
            chk($sformatf("blk01_byte%0d", i), ct_q[i],
                ((i < 64) ? ref0[i*8 +: 8] : ref1[(i-64)*8 +: 8]) ^ pt_buf[i]);
        wait_ctr(24);
        repeat (20) @(posedge clk);
        chk("ctr_write_count", ctr_log.size(), 24);
        for (int i = 0; i < 24; i++)
            chk($sformatf("ctr_log%0d", i), ctr_log[i], (i % 8 == 0) ? 8'(i / 8) : 8'h00);
        chk("ctr_wrap_zero", ctr_wrap, 0);

        // Test 3: gapped pt and random ct_ready on block 0.
        ct_mode = 1;
        ct_q.delete();
        for (int i = 0; i < 64; i++) pt_buf[i] = 8'(i * 7 + 3);
        do_load('0, '0, 1'b0);
        send_pt(64, 1'b1);
        wait_q(64);
        repeat (30) @(posedge clk);
        chk("bp_count", ct_q.size(), 64);
        for (int i = 0; i < 64; i++)
            chk($sformatf("bp_byte%0d", i), ct_q[i], ref0[i*8 +: 8] ^ pt_buf[i]);
        ct_mode = 0;

        // Test 4: abort after 20 STREAM bytes, then reload from LD_KEY.
        ct_q.delete();
        for (int i = 0; i < 64; i++) pt_buf[i] = 8'(i) ^ 8'h5a;
        do_load(key_k, nnc_k, 1'b1);
        chk("load_key_cnt", nkey, 32);
        chk("load_nnc_cnt", nnnc, 8);
        send_pt(20, 1'b0);
        cmd_load = 1'b1; ct_mode = 2; mk = 0; mn = 0; mc = 0;
        @(negedge clk);
        nkey = 0; nnnc = 0;
        chk("abort_pre_ctvld", ct_valid, 1);
        @(posedge clk); #1;
        cmd_load = 1'b0; ct_mode = 0;
        chk("abort_ctvld", ct_valid, 0);
        chk("abort_state", {cfg_ready, pt_ready, busy}, 3'b101);
        chk("abort_rd_cnt", rd_i, 20);
        chk("abort_ct_cnt", ct_q.size(), 19);
        for (int i = 0; i < 19; i++)
            chk($sformatf("abort_byte%0d", i), ct_q[i], refk[i*8 +: 8] ^ pt_buf[i]);
        send_cfg(1'b1);
        repeat (2) @(posedge clk);
        chk("reload_key_cnt", nkey, 32);
        chk("reload_nnc_cnt", nnnc, 8);
        chk("reload_key_before_nnc", key_at_nnc, 32);
        ct_q.delete();
        send_pt(64, 1'b0);
        wait_q(64);
        for (int i = 0; i < 64; i++)
            chk($sformatf("key_byte%0d", i), ct_q[i], refk[i*8 +: 8] ^ pt_buf[i]);

        // Test 6a: reset while in WAIT_BLK.
        begin
            int g = 0;
            while (!core_wr_ctr && g < 200) begin @(negedge clk); g++; end
            while (core_wr_ctr && g < 200) begin @(negedge clk); g++; end
            chk("wait_blk_reached", {busy, core_ready, g < 200}, 3'b101);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_wait");
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_reset("rst_hold_idle");

        // Test 6b: reset while STREAM holds a ciphertext byte.
        do_load('0, '0, 1'b0);
        ct_mode = 2;
        pt_buf[0] = 8'h00;
        send_pt(1, 1'b0);
        @(negedge clk);
        chk("stream_held", {ct_valid, ct_data}, {1'b1, ref0[7:0]});
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_stream");
        rst = 1'b0;
        ct_mode = 0;

`ifdef CHACHA_STREAM_SEQ_SEEK_EN
        // Test 5: seek to all-ones counter, wrap after one block.
        ctr_init = '1;
        ctr_log.delete(); ct_q.delete();
        for (int i = 0; i < 64; i++) pt_buf[i] = 8'h00;
        do_load('0, '0, 1'b0);
        send_pt(64, 1'b0);
        wait_q(64);
        wait_ctr(16);
        chk("seek_wrap", ctr_wrap, 1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("seek_ctr%0d", i), ctr_log[i], (i < 8) ? 8'hff : 8'h00);
        for (int i = 0; i < 64; i++)
            chk($sformatf("seek_byte%0d", i), ct_q[i], reff[i*8 +: 8]);
        @(posedge clk); #1;
        cmd_load = 1'b1;
        @(posedge clk); #1;
        cmd_load = 1'b0;
        chk("wrap_cleared", ctr_wrap, 0);
`else
        // Test 5 (no seek): counter always restarts at 0.
        ctr_init = '1;
        ctr_log.delete();
        do_load('0, '0, 1'b0);
        wait_ctr(8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("noseek_ctr%0d", i), ctr_log[i], 8'h00);
        chk("noseek_wrap", ctr_wrap, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
